// File: rtl/ps2_pkg.sv
// PS/2 keyboard shared types, prefix bytes and the
// set-2 scan code to Hack key code translation.
package ps2_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam logic [15:0] KEY_NEWLINE   = 16'd128;
  localparam logic [15:0] KEY_BACKSPACE = 16'd129;
  localparam logic [15:0] KEY_LEFT      = 16'd130;
  localparam logic [15:0] KEY_UP        = 16'd131;
  localparam logic [15:0] KEY_RIGHT     = 16'd132;
  localparam logic [15:0] KEY_DOWN      = 16'd133;
  localparam logic [15:0] KEY_HOME      = 16'd134;
  localparam logic [15:0] KEY_END       = 16'd135;
  localparam logic [15:0] KEY_PGUP      = 16'd136;
  localparam logic [15:0] KEY_PGDN      = 16'd137;
  localparam logic [15:0] KEY_INSERT    = 16'd138;
  localparam logic [15:0] KEY_DELETE    = 16'd139;
  localparam logic [15:0] KEY_ESC       = 16'd140;
  localparam logic [15:0] KEY_F1        = 16'd141;

  // Returns 0 for any byte without a Hack equivalent
  function automatic logic [15:0] ps2_to_hack(
    input logic       ext,
    input logic [7:0] b
  );
    logic [15:0] r;
    r = '0;
    if (ext) begin
      case (b)
        8'h6B: r = KEY_LEFT;
        8'h75: r = KEY_UP;
        8'h74: r = KEY_RIGHT;
        8'h72: r = KEY_DOWN;
        8'h6C: r = KEY_HOME;
        8'h69: r = KEY_END;
        8'h7D: r = KEY_PGUP;
        8'h7A: r = KEY_PGDN;
        8'h70: r = KEY_INSERT;
        8'h71: r = KEY_DELETE;
        default: r = '0;
      endcase
    end else begin
      case (b)
        8'h1C: r = 16'd65;  8'h32: r = 16'd66;
        8'h21: r = 16'd67;  8'h23: r = 16'd68;
        8'h24: r = 16'd69;  8'h2B: r = 16'd70;
        8'h34: r = 16'd71;  8'h33: r = 16'd72;
        8'h43: r = 16'd73;  8'h3B: r = 16'd74;
        8'h42: r = 16'd75;  8'h4B: r = 16'd76;
        8'h3A: r = 16'd77;  8'h31: r = 16'd78;
        8'h44: r = 16'd79;  8'h4D: r = 16'd80;
        8'h15: r = 16'd81;  8'h2D: r = 16'd82;
        8'h1B: r = 16'd83;  8'h2C: r = 16'd84;
        8'h3C: r = 16'd85;  8'h2A: r = 16'd86;
        8'h1D: r = 16'd87;  8'h22: r = 16'd88;
        8'h35: r = 16'd89;  8'h1A: r = 16'd90;
        8'h45: r = 16'd48;  8'h16: r = 16'd49;
        8'h1E: r = 16'd50;  8'h26: r = 16'd51;
        8'h25: r = 16'd52;  8'h2E: r = 16'd53;
        8'h36: r = 16'd54;  8'h3D: r = 16'd55;
        8'h3E: r = 16'd56;  8'h46: r = 16'd57;
        8'h29: r = 16'd32;
        8'h5A: r = KEY_NEWLINE;
        8'h66: r = KEY_BACKSPACE;
        8'h76: r = KEY_ESC;
        8'h05: r = KEY_F1;
        8'h06: r = KEY_F1 + 16'd1;
        8'h04: r = KEY_F1 + 16'd2;
        8'h0C: r = KEY_F1 + 16'd3;
        8'h03: r = KEY_F1 + 16'd4;
        8'h0B: r = KEY_F1 + 16'd5;
        8'h83: r = KEY_F1 + 16'd6;
        8'h0A: r = KEY_F1 + 16'd7;
        8'h01: r = KEY_F1 + 16'd8;
        8'h09: r = KEY_F1 + 16'd9;
        8'h78: r = KEY_F1 + 16'd10;
        8'h07: r = KEY_F1 + 16'd11;
        default: r = '0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_keyboard_if.sv
// PS/2 pins in, Hack key code and status pulses out.
interface ps2_keyboard_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] scancode;
  logic        key_strobe;
  logic        frame_error;

  modport master (
    output ps2_clk, ps2_data,
    input  scancode, key_strobe, frame_error
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output scancode, key_strobe, frame_error
  );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronizer, clock glitch
// filter, start/data/parity/stop FSM and frame timeout.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER         = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_error
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_dat_sync;
  logic          r_filt;
  logic [FW-1:0] r_fcnt;
  rx_state_e     r_state;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_tcnt;

  logic w_clk_s;
  logic w_dat;
  logic w_fall;

  assign w_clk_s = r_clk_sync[1];
  assign w_dat   = r_dat_sync[1];
  // Last of FILTER consecutive low samples while filtered level is high
  assign w_fall  = r_filt && !w_clk_s &&
                   (r_fcnt == FW'(FILTER - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_filt     <= 1'b1;
      r_fcnt     <= '0;
    end else begin
      r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[0], i_ps2_data};
      if (w_clk_s == r_filt) begin
        r_fcnt <= '0;
      end else if (r_fcnt == FW'(FILTER - 1)) begin
        r_filt <= w_clk_s;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_bitcnt      <= '0;
      r_shift       <= '0;
      r_par         <= 1'b0;
      r_tcnt        <= '0;
      o_byte        <= '0;
      o_byte_valid  <= 1'b0;
      o_frame_error <= 1'b0;
    end else begin
      o_byte_valid  <= 1'b0;
      o_frame_error <= 1'b0;
      if (w_fall) begin
        r_tcnt <= '0;
        case (r_state)
          S_IDLE: begin
            if (!w_dat) begin
              r_state  <= S_DATA;
              r_bitcnt <= '0;
              r_par    <= 1'b0;
            end
          end
          S_DATA: begin
            r_shift  <= {w_dat, r_shift[7:1]};
            r_par    <= r_par ^ w_dat;
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == 3'd7) r_state <= S_PARITY;
          end
          S_PARITY: begin
            r_par   <= r_par ^ w_dat;
            r_state <= S_STOP;
          end
          S_STOP: begin
            r_state <= S_IDLE;
            if (r_par && w_dat) begin
              o_byte       <= r_shift;
              o_byte_valid <= 1'b1;
            end else begin
              o_frame_error <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (r_state != S_IDLE) begin
        if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          r_state       <= S_IDLE;
          r_tcnt        <= '0;
          o_frame_error <= 1'b1;
        end else begin
          r_tcnt <= r_tcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard to Hack keyboard register: prefix
// tracking and the held-key scancode register.
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int FILTER         = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic           clock,
  input logic           reset,
  ps2_keyboard_if.slave bus
);

  logic [7:0]  w_byte;
  logic        w_byte_valid;
  logic        w_frame_error;
  logic [15:0] w_code;

  logic        r_ext;
  logic        r_brk;
  logic [15:0] r_scancode;
  logic        r_strobe;

  ps2_rx #(
    .FILTER        (FILTER),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .i_clk        (clock),
    .i_rst        (reset),
    .i_ps2_clk    (bus.ps2_clk),
    .i_ps2_data   (bus.ps2_data),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_frame_error(w_frame_error)
  );

  assign w_code = ps2_to_hack(r_ext, w_byte);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ext      <= 1'b0;
      r_brk      <= 1'b0;
      r_scancode <= '0;
      r_strobe   <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (w_frame_error) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (w_byte_valid) begin
        unique case (1'b1)
          (w_byte == PS2_EXT): r_ext <= 1'b1;
          (w_byte == PS2_BRK): r_brk <= 1'b1;
          default: begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
            // A break only clears the key it names
            if (!r_brk && w_code != '0) begin
              r_scancode <= w_code;
              r_strobe   <= 1'b1;
            end else if (r_brk && w_code == r_scancode) begin
              r_scancode <= '0;
            end
          end
        endcase
      end
    end
  end

  assign bus.scancode    = r_scancode;
  assign bus.key_strobe  = r_strobe;
  assign bus.frame_error = w_frame_error;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Randomized PS/2 stimulus against a table-driven model
// of the key map and make/break/extended decoding.
module tb_ps2_keyboard;

  localparam int FILTER = 4;
  localparam int TMO    = 300;
  localparam int H      = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  ps2_keyboard_if bus();

  ps2_keyboard #(
    .FILTER        (FILTER),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int base_map[int];
  int ext_map[int];
  int keys[$];

  int m_held = 0;
  bit m_ext  = 0;
  bit m_brk  = 0;
  int exp_strobes = 0;
  int exp_errs    = 0;

  int strobes = 0;
  int errs    = 0;
  int viol    = 0;
  bit prev_ks = 0;
  bit prev_fe = 0;
  int t_fall  = 0;

  always @(negedge clock) begin
    if (!reset) begin
      if (bus.key_strobe) strobes++;
      if (bus.frame_error) errs++;
      if (bus.key_strobe && bus.frame_error) viol++;
      if (bus.key_strobe && prev_ks) viol++;
      if (bus.frame_error && prev_fe) viol++;
    end
    prev_ks = bus.key_strobe;
    prev_fe = bus.frame_error;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic int xlate(input bit ext, input int b);
    if (ext) return ext_map.exists(b) ? ext_map[b] : 0;
    return base_map.exists(b) ? base_map[b] : 0;
  endfunction

  task automatic build_maps();
    bit [7:0] lt[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24,
      8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A,
      8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
      8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    bit [7:0] dg[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
      8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    bit [7:0] fk[12] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03,
      8'h0B, 8'h83, 8'h0A, 8'h01, 8'h09, 8'h78, 8'h07};
    bit [7:0] ex[10] = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C,
      8'h69, 8'h7D, 8'h7A, 8'h70, 8'h71};
    for (int i = 0; i < 26; i++) base_map[lt[i]] = 65 + i;
    for (int i = 0; i < 10; i++) base_map[dg[i]] = 48 + i;
    for (int i = 0; i < 12; i++) base_map[fk[i]] = 141 + i;
    for (int i = 0; i < 10; i++) ext_map[ex[i]] = 130 + i;
    base_map[8'h29] = 32;
    base_map[8'h5A] = 128;
    base_map[8'h66] = 129;
    base_map[8'h76] = 140;
    foreach (base_map[k]) keys.push_back(k);
    foreach (ext_map[k]) keys.push_back(k | 256);
  endtask

  // Drives the first nbits of a frame, optionally with
  // single-cycle clock glitches in both phases.
  task automatic send_bits(input logic [7:0] b, input int nbits,
                           input bit bad_par, input bit bad_stop,
                           input bit glitch);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = fr[i];
      if (glitch && $urandom_range(0, 3) == 0) begin
        tick(H / 2);
        bus.ps2_clk = 1'b0;
        tick(1);
        bus.ps2_clk = 1'b1;
        tick(H - H / 2 - 1);
      end else begin
        tick(H);
      end
      bus.ps2_clk = 1'b0;
      t_fall = cyc;
      if (glitch && $urandom_range(0, 3) == 0) begin
        tick(H / 2);
        bus.ps2_clk = 1'b1;
        tick(1);
        bus.ps2_clk = 1'b0;
        tick(H - H / 2 - 1);
      end else begin
        tick(H);
      end
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
    tick(H);
  endtask

  task automatic model_byte(input int b, input bit ok);
    int code;
    if (!ok) begin
      m_ext = 0;
      m_brk = 0;
      exp_errs++;
      return;
    end
    if (b == 'hE0) m_ext = 1;
    else if (b == 'hF0) m_brk = 1;
    else begin
      code = xlate(m_ext, b);
      if (!m_brk) begin
        if (code != 0) begin
          m_held = code;
          exp_strobes++;
        end
      end else if (code == m_held) begin
        m_held = 0;
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic send_byte(input int b, input bit bad_par = 0,
                           input bit bad_stop = 0,
                           input bit glitch = 0);
    send_bits(b[7:0], 11, bad_par, bad_stop, glitch);
    model_byte(b, !(bad_par || bad_stop));
  endtask

  task automatic check_state(input string tag);
    check({tag, ".scancode"}, bus.scancode, m_held);
    check({tag, ".strobes"}, strobes, exp_strobes);
    check({tag, ".errors"}, errs, exp_errs);
  endtask

  task automatic press(input int k, input bit g = 0);
    if (k & 256) send_byte('hE0, 0, 0, g);
    send_byte(k & 255, 0, 0, g);
  endtask

  task automatic release_key(input int k, input bit g = 0);
    if (k & 256) send_byte('hE0, 0, 0, g);
    send_byte('hF0, 0, 0, g);
    send_byte(k & 255, 0, 0, g);
  endtask

  initial begin
    int got;
    int k;
    int op;
    build_maps();
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    reset = 1'b1;
    tick(5);
    check("reset.scancode", bus.scancode, 0);
    check("reset.strobe", bus.key_strobe, 0);
    check("reset.ferr", bus.frame_error, 0);
    reset = 1'b0;
    tick(5);

    press('h1C);
    check_state("make_A");
    check("make_A.value", bus.scancode, 65);
    release_key('h1C);
    check_state("break_A");

    press('h175);
    check_state("make_up");
    check("make_up.value", bus.scancode, 131);
    release_key('h175);
    check_state("break_up");
    send_byte('h75);
    check_state("plain_75");

    press('h1C);
    press('h1A);
    check_state("overwrite_Z");
    release_key('h1C);
    check_state("break_A_held_Z");
    release_key('h1A);
    check_state("break_Z");

    press('h1C);
    press('h1C);
    check_state("typematic");
    send_byte('h1A, 1, 0);
    check_state("bad_parity");
    send_byte('h1A, 0, 1);
    check_state("bad_stop");
    send_byte('hAA);
    send_byte('hFA);
    check_state("unmapped");

    send_bits(8'h1A, 5, 0, 0, 0);
    got = -1;
    for (int i = 0; i < TMO + 200; i++) begin
      @(negedge clock);
      if (bus.frame_error) begin
        got = cyc - t_fall;
        break;
      end
    end
    check("timeout_latency", got, TMO + FILTER + 2);
    model_byte(0, 0);
    tick(4);
    check_state("timeout");
    press('h1A);
    check_state("after_timeout");

    press('h5A, 1);
    check_state("glitch_enter");

    send_bits(8'h2D, 5, 0, 0, 0);
    reset = 1'b1;
    tick(3);
    check("midreset.scancode", bus.scancode, 0);
    check("midreset.strobe", bus.key_strobe, 0);
    check("midreset.ferr", bus.frame_error, 0);
    reset = 1'b0;
    m_held = 0;
    m_ext  = 0;
    m_brk  = 0;
    tick(4);
    check_state("after_reset");
    press('h2D);
    check_state("post_reset_R");

    for (int n = 0; n < 30; n++) begin
      op = $urandom_range(0, 9);
      k  = keys[$urandom_range(0, keys.size() - 1)];
      if (op <= 5) begin
        press(k, 1);
      end else if (op <= 8) begin
        if ($urandom_range(0, 1) == 1 && m_held != 0) begin
          foreach (keys[j])
            if (xlate(keys[j][8], keys[j] & 255) == m_held)
              k = keys[j];
        end
        release_key(k, 1);
      end else begin
        case ($urandom_range(0, 2))
          0: send_byte('hAA, 0, 0, 1);
          1: send_byte('hFA, 0, 0, 1);
          default: send_byte('h75, 0, 0, 1);
        endcase
      end
      check_state($sformatf("rand%0d", n));
    end

    check("pulse_rules", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard.md
# ps2_keyboard

Receives the PS/2 keyboard serial stream, deserializes frames, and tracks make/break/extended prefixes. Drives the 16-bit Hack keyboard code that the memory map returns at the keyboard address (0x6000). Output holds the code of the most recently pressed key while it is held and returns to 0 on its release. Sits directly upstream of the memory block's `scancode` input.

## Interface
- `FILTER`, 4: consecutive identical samples of synchronized `ps2_clk` required to accept a level change.
- `TIMEOUT_CYCLES`, 50000: `clock` cycles without a filtered falling edge, mid-frame, before the frame is abandoned.

- `clock` in 1: system clock; everything is sampled on its rising edge.
- `reset` in 1: synchronous, active-high.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous, idles high.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous, idles high.
- `scancode` out 16: Hack key code of the held key, or 0.
- `key_strobe` out 1: one-cycle pulse whenever a make code loads `scancode`.
- `frame_error` out 1: one-cycle pulse on a parity error, a bad stop bit, or a timeout.

## Operation
- Both pins pass through a 2-flop synchronizer. `ps2_clk` is then filtered: the filtered level changes only after `FILTER` equal consecutive samples. A data bit is sampled on each filtered high-to-low transition.
- Frame: start(0), 8 data bits LSB first, odd parity, stop(1).
- Receiver FSM:
  - IDLE → DATA on an edge with data=0. An edge with data=1 in IDLE is ignored.
  - DATA → PARITY after 8 bits.
  - PARITY → STOP after the parity bit.
  - STOP → IDLE after the stop bit. The byte is delivered only if parity is odd and stop=1. Otherwise `frame_error` pulses and the byte is discarded.
- Timeout: the cycle counter clears on every filtered falling edge. In any state except IDLE, reaching `TIMEOUT_CYCLES` forces IDLE and pulses `frame_error`.
- Decoder, on each delivered byte:
  - 0xE0 sets `ext`.
  - 0xF0 sets `brk`.
  - Any other byte is translated with (`ext`, byte) → Hack code; then `ext` and `brk` clear.
  - Make (`brk`=0) with a nonzero translation: `scancode` ← code, `key_strobe` pulses. This applies to typematic repeats too (value unchanged, strobe pulses again). It also applies while another key is held (overwrite).
  - Break (`brk`=1): `scancode` ← 0 only if the translation equals the current `scancode`. Otherwise no change.
  - Unmapped bytes (translation 0, including 0xAA and 0xFA) change nothing, but still clear the flags.
  - A `frame_error` also clears `ext` and `brk`.
- Translation (shift is not tracked; letters are always uppercase):
  - Letters: A=0x1C → 65 … Z=0x1A → 90.
  - Digits: 0=0x45 → 48, 1=0x16 → 49 … 9 → 57.
  - Space 0x29 → 32; Enter 0x5A → 128; Backspace 0x66 → 129.
  - Extended: Left E0 6B → 130, Up E0 75 → 131, Right E0 74 → 132, Down E0 72 → 133, Home E0 6C → 134, End E0 69 → 135, PgUp E0 7D → 136, PgDn E0 7A → 137, Insert E0 70 → 138, Delete E0 71 → 139.
  - Esc 0x76 → 140; F1..F12 → 141..152.

## Timing
- Reset values: `scancode`=0, `key_strobe`=0, `frame_error`=0, FSM=IDLE, `ext`=`brk`=0, bit count and timeout counter 0.
- Reset mid-frame abandons the partial byte with no `frame_error` pulse.
- Edge detect latency: 2 (sync) + `FILTER` cycles after the pin edge.
- `scancode` and `key_strobe` update on the cycle after the stop bit's filtered falling edge is processed.
- `frame_error` has the same timing as a delivered byte. For a timeout it fires on the cycle the counter reaches `TIMEOUT_CYCLES`.
- Pulses never last more than one cycle. `key_strobe` and `frame_error` are never both high in the same cycle.
- The block is never back-pressured. The consumer samples `scancode` combinationally through the memory mux.

## Structure
- Package `ps2_pkg`:
  - receiver state enum;
  - prefix constants 0xE0 and 0xF0;
  - Hack key constants 128–152;
  - function `ps2_to_hack(ext, byte) → 16-bit`, returning 0 when unmapped.
- Sub-module `ps2_rx`: synchronizer, filter, FSM, and timeout. It outputs `byte[7:0]`, `byte_valid`, and `frame_error`. The top holds the prefix flags and the `scancode` register.

## Test plan
- Frame 0x1C (A), correct parity → `scancode`=65, one `key_strobe`. Then F0 1C → `scancode`=0, no strobe.
- E0 75 → 131. Then E0 F0 75 → 0. Plain 0x75 with `ext`=0 is unmapped → no change.
- Hold A (65), make 0x1A → 90 with a strobe. Break 1C → stays 90. Break 1A → 0.
- Wrong parity on 0x1C → `frame_error` pulse, `scancode` unchanged. Stop bit 0 → same.
- Stop toggling `ps2_clk` after 4 data bits → `frame_error` exactly `TIMEOUT_CYCLES` cycles after the last edge. The next valid frame decodes normally.
- 1-cycle glitches on `ps2_clk` (shorter than `FILTER`) in mid-frame → ignored, correct byte delivered. `reset` asserted mid-frame → all outputs 0, and the next full frame decodes correctly.
